// File: rtl/seven_seg_scan.sv
// seven_seg_scan: shows a BITS-wide result in hex on a scanned, active-low multi-digit display.
// Define SEVEN_SEG_SIGNED_EN to show sign and magnitude instead of the raw two's-complement hex.
module seven_seg_scan #(
    parameter int BITS           = 16,
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  CPU_RESETN,
    input  logic [BITS-1:0]       data_in,
    input  logic                  data_valid,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            cathode,
    output logic                  frame_start
);
    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int ND = BITS / 4;

    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] pend, disp, disp_nxt, val;
    logic            pend_flag, boundary, neg, wrap;
    logic [3:0]      nib;
    logic [6:0]      seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Segments are decoded from the post-load value so the first digit of a frame already shows the new word.
    always_comb begin
        boundary = idx == '0 && cnt == '0;
        wrap     = cnt == CW'(REFRESH_CYCLES - 1);
        disp_nxt = boundary && pend_flag ? pend : disp;
`ifdef SEVEN_SEG_SIGNED_EN
        neg = disp_nxt[BITS-1];
        val = neg ? -disp_nxt : disp_nxt;
`else
        neg = 1'b0;
        val = disp_nxt;
`endif
        nib = 4'(val >> {idx, 2'b00});
        seg = idx < IW'(ND) ? hex7(nib) : (idx == IW'(ND) && neg) ? 7'h3F : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (!CPU_RESETN) begin
            cnt         <= '0;
            idx         <= '0;
            pend        <= '0;
            pend_flag   <= 1'b0;
            disp        <= '0;
            anode       <= '1;
            cathode     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            cnt         <= wrap ? '0 : cnt + 1'b1;
            idx         <= !wrap ? idx : idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            disp        <= disp_nxt;
            pend_flag   <= data_valid || (pend_flag && !boundary);
            pend        <= data_valid ? data_in : pend;
            anode       <= cnt < CW'(BLANK_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << idx);
            cathode     <= {1'b1, seg};
            frame_start <= boundary;
        end
    end
endmodule
